// File: rtl/ofdm_cp_insert_ctrl_pkg.sv
// ofdm_cp_insert_ctrl_pkg: shared read-FSM encoding and symbol geometry for the CP inserter
package ofdm_cp_insert_ctrl_pkg;
  localparam int FFT_LOG2_DEF = 6;
  localparam int N = 1 << FFT_LOG2_DEF;
  localparam int ADDR_W = FFT_LOG2_DEF + 1;
  typedef enum logic [1:0] {IDLE = 2'd0, CP = 2'd1, BODY = 2'd2} rd_state_t;
endpackage

// File: rtl/ofdm_cp_insert_ctrl_mem.sv
// memForOFDM: two-bank I/Q symbol store with one write port and a registered read port
module memForOFDM #(
  parameter int MEMORY_SYZE = 7,
  parameter int DATA_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [MEMORY_SYZE-1:0] wr_addr,
  input  logic [DATA_SIZE-1:0]   wr_i,
  input  logic [DATA_SIZE-1:0]   wr_q,
  input  logic                   rd_en,
  input  logic [MEMORY_SYZE-1:0] rd_addr,
  output logic [DATA_SIZE-1:0]   rd_i,
  output logic [DATA_SIZE-1:0]   rd_q
);
  logic [2*DATA_SIZE-1:0] mem [2**MEMORY_SYZE];
  // sample storage, contents undefined after reset
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= {wr_i, wr_q};
  // read register only advances on an issued read so the output holds between samples
  always_ff @(posedge clk or posedge rst)
    if (rst) {rd_i, rd_q} <= '0;
    else if (rd_en) {rd_i, rd_q} <= mem[rd_addr];
endmodule

// File: rtl/ofdm_cp_insert_ctrl.sv
// ofdm_cp_insert_ctrl: ping-pong symbol buffer that replays the symbol tail as cyclic prefix
module ofdm_cp_insert_ctrl
  import ofdm_cp_insert_ctrl_pkg::*;
#(
  parameter int FFT_LOG2 = ADDR_W - 1,
  parameter int CP_LEN = 16,
  parameter int DATA_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_i,
  input  logic [DATA_SIZE-1:0] in_q,
  output logic                 out_valid,
  output logic [DATA_SIZE-1:0] out_i,
  output logic [DATA_SIZE-1:0] out_q,
  output logic                 out_sop,
  output logic                 out_eop
);
  localparam int NS = 1 << FFT_LOG2;
  localparam logic [FFT_LOG2-1:0] CP_START = FFT_LOG2'(NS - CP_LEN);
  localparam logic [FFT_LOG2-1:0] IDX_LAST = FFT_LOG2'(NS - 1);
  rd_state_t state, state_nxt;
  logic [FFT_LOG2-1:0] wr_cnt, rd_idx, rd_idx_nxt;
  logic wr_bank, rd_bank, wr_en, wr_last, issue, sop_issue, eop_issue;
  logic [1:0] bank_full, bank_full_nxt;
  assign in_ready = !bank_full[wr_bank] && !flush;
  assign wr_en = in_valid && in_ready;
  assign wr_last = wr_en && wr_cnt == IDX_LAST;
  // read sequencer: tail of the symbol as prefix, then the whole symbol, chaining when the other bank is ready
  always_comb begin
    state_nxt = state;
    rd_idx_nxt = rd_idx + 1'b1;
    issue = 1'b0;
    sop_issue = 1'b0;
    eop_issue = 1'b0;
    case (state)
      IDLE: begin
        rd_idx_nxt = CP_START;
        state_nxt = bank_full[rd_bank] ? CP : IDLE;
      end
      CP: begin
        issue = 1'b1;
        sop_issue = rd_idx == CP_START;
        state_nxt = rd_idx == IDX_LAST ? BODY : CP;
      end
      BODY: begin
        issue = 1'b1;
        eop_issue = rd_idx == IDX_LAST;
        if (eop_issue) begin
          rd_idx_nxt = CP_START;
          state_nxt = (bank_full[!rd_bank] || (wr_last && wr_bank != rd_bank)) ? CP : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
  // fill and drain flags; set and clear always land on different banks
  always_comb begin
    bank_full_nxt = bank_full;
    if (wr_last) bank_full_nxt[wr_bank] = 1'b1;
    if (eop_issue) bank_full_nxt[rd_bank] = 1'b0;
  end
  // control state, with flush discarding any buffered or partial symbol
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rd_idx <= '0;
      wr_cnt <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      bank_full <= '0;
      out_valid <= 1'b0;
      out_sop <= 1'b0;
      out_eop <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      rd_idx <= '0;
      wr_cnt <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      bank_full <= '0;
      out_valid <= 1'b0;
      out_sop <= 1'b0;
      out_eop <= 1'b0;
    end else begin
      state <= state_nxt;
      rd_idx <= rd_idx_nxt;
      bank_full <= bank_full_nxt;
      if (wr_en) wr_cnt <= wr_cnt + 1'b1;
      if (wr_last) wr_bank <= !wr_bank;
      if (eop_issue) rd_bank <= !rd_bank;
      out_valid <= issue;
      out_sop <= sop_issue;
      out_eop <= eop_issue;
    end
  memForOFDM #(.MEMORY_SYZE(FFT_LOG2 + 1), .DATA_SIZE(DATA_SIZE)) u_sym_mem (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_addr({wr_bank, wr_cnt}),
    .wr_i(in_i),
    .wr_q(in_q),
    .rd_en(issue && !flush),
    .rd_addr({rd_bank, rd_idx}),
    .rd_i(out_i),
    .rd_q(out_q)
  );
endmodule

// File: tb/tb_ofdm_cp_insert_ctrl.sv
// tb_ofdm_cp_insert_ctrl: scoreboard bench for the cyclic-prefix inserter
module tb_ofdm_cp_insert_ctrl;
  import ofdm_cp_insert_ctrl_pkg::*;
  localparam int CPL = 16;
  localparam int SYM = N + CPL;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0;
  logic [15:0] in_i = '0, in_q = '0, out_i, out_q;
  logic in_ready, out_valid, out_sop, out_eop;
  int compared = 0, mismatched = 0;
  int wcnt = 0, cyc = 0, vcount = 0, first_cyc = 0, last_cyc = 0, last_acc_cyc = 0;
  bit arm = 1'b0;
  logic [33:0] exp_q[$];
  logic [31:0] sym_buf[N];

  always #5 clk = ~clk;

  ofdm_cp_insert_ctrl #(.FFT_LOG2(6), .CP_LEN(CPL), .DATA_SIZE(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_i(in_i), .in_q(in_q), .out_valid(out_valid), .out_i(out_i), .out_q(out_q),
    .out_sop(out_sop), .out_eop(out_eop)
  );

  task automatic monitor();
    logic [33:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst && out_valid) begin
        vcount++;
        last_cyc = cyc;
        if (arm) begin first_cyc = cyc; arm = 1'b0; end
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_out: got i=%0d q=%0d sop=%0b eop=%0b, no sample expected", out_i, out_q, out_sop, out_eop);
        end else begin
          e = exp_q.pop_front();
          if ({out_i, out_q, out_sop, out_eop} !== e) begin
            mismatched++;
            $display("FAIL stream: got i=%0d q=%0d sop=%0b eop=%0b, expected i=%0d q=%0d sop=%0b eop=%0b",
                     out_i, out_q, out_sop, out_eop, e[33:18], e[17:2], e[1], e[0]);
          end
        end
      end
    end
  endtask

  task automatic push_sym();
    int k;
    for (int j = 0; j < SYM; j++) begin
      k = j < CPL ? N - CPL + j : j - CPL;
      exp_q.push_back({sym_buf[k], j == 0, j == SYM - 1});
    end
  endtask

  task automatic send(input logic [15:0] i, input logic [15:0] q, input int gap);
    int budget;
    repeat (gap) begin @(negedge clk); in_valid = 1'b0; end
    @(negedge clk);
    in_valid = 1'b1; in_i = i; in_q = q;
    #1;
    budget = 500;
    while (!in_ready && budget > 0) begin @(negedge clk); #1; budget--; end
    if (!in_ready) begin
      compared++; mismatched++;
      in_valid = 1'b0;
      $display("FAIL accept_timeout: in_ready=%0b, required 1 within 500 cycles", in_ready);
    end else begin
      last_acc_cyc = cyc;
      sym_buf[wcnt] = {i, q};
      wcnt++;
      if (wcnt == N) begin push_sym(); wcnt = 0; end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); in_valid = 1'b0; end
  endtask

  task automatic drain();
    int budget = 2000;
    idle(1);
    while (exp_q.size() > 0 && budget > 0) begin @(negedge clk); budget--; end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain_timeout: %0d samples still pending, required 0", exp_q.size());
      exp_q.delete();
    end
    idle(4);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    compared++;
    if ({out_valid, out_sop, out_eop, in_ready} !== 4'b0001) begin
      mismatched++;
      $display("FAIL reset_flags: got valid/sop/eop/ready=%b, required 0001", {out_valid, out_sop, out_eop, in_ready});
    end
    compared++;
    if ({out_i, out_q} !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_data: got i=%0d q=%0d, required 0 0", out_i, out_q);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    int v0 = vcount;
    for (int k = 0; k < N; k++) send(16'(k), 16'(-k), 0);
    @(negedge clk); in_valid = 1'b0;
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL latency_early1: out_valid=%0b, required 0", out_valid); end
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL latency_early2: out_valid=%0b, required 0", out_valid); end
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b1) begin mismatched++; $display("FAIL latency_first: out_valid=%0b, required 1", out_valid); end
    drain();
    compared++;
    if (vcount - v0 != SYM) begin mismatched++; $display("FAIL single_count: got %0d outputs, required %0d", vcount - v0, SYM); end
  endtask

  task automatic test_back_to_back();
    int v0 = vcount;
    int done[4];
    arm = 1'b1;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < N; k++) send(16'($urandom()), 16'($urandom()), 0);
      done[s] = last_acc_cyc;
    end
    drain();
    compared++;
    if (vcount - v0 != 4 * SYM) begin mismatched++; $display("FAIL b2b_count: got %0d outputs, required %0d", vcount - v0, 4 * SYM); end
    compared++;
    if (last_cyc - first_cyc + 1 != 4 * SYM) begin mismatched++; $display("FAIL b2b_gapless: span %0d cycles, required %0d", last_cyc - first_cyc + 1, 4 * SYM); end
    compared++;
    if (done[3] - done[2] != SYM) begin mismatched++; $display("FAIL b2b_input_rate: %0d cycles per symbol, required %0d", done[3] - done[2], SYM); end
  endtask

  task automatic test_stall();
    int budget = 300;
    bit early = 1'b0;
    for (int k = 0; k < 2 * N; k++) send(16'(1000 + k), 16'(k), 0);
    @(negedge clk); in_valid = 1'b0;
    #1;
    compared++;
    if (in_ready !== 1'b0) begin mismatched++; $display("FAIL stall_full: in_ready=%0b, required 0", in_ready); end
    do begin
      @(negedge clk); #1;
      if (!out_eop && in_ready) early = 1'b1;
      budget--;
    end while (!out_eop && budget > 0);
    compared++;
    if (early) begin mismatched++; $display("FAIL stall_early_ready: in_ready=1 before bank 0 eop, required 0"); end
    compared++;
    if ({in_ready, out_eop} !== 2'b11) begin mismatched++; $display("FAIL stall_release: in_ready=%0b eop=%0b, required 1 1", in_ready, out_eop); end
    drain();
  endtask

  task automatic test_sparse();
    int v0 = vcount;
    arm = 1'b1;
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < N; k++) send(16'(k * 3 + s), 16'(~k), 2);
    drain();
    compared++;
    if (vcount - v0 != 2 * SYM) begin mismatched++; $display("FAIL sparse_count: got %0d outputs, required %0d", vcount - v0, 2 * SYM); end
    compared++;
    if (last_cyc - first_cyc + 1 <= 2 * SYM) begin mismatched++; $display("FAIL sparse_gap: span %0d cycles, required more than %0d", last_cyc - first_cyc + 1, 2 * SYM); end
  endtask

  task automatic test_flush();
    int v0 = vcount;
    for (int k = 0; k < 30; k++) send(16'(500 + k), 16'd0, 0);
    @(negedge clk); in_valid = 1'b0; flush = 1'b1;
    #1;
    compared++;
    if (in_ready !== 1'b0) begin mismatched++; $display("FAIL flush_ready: in_ready=%0b during flush, required 0", in_ready); end
    @(negedge clk); flush = 1'b0;
    wcnt = 0;
    for (int k = 0; k < N; k++) send(16'd7, 16'd7, 0);
    drain();
    compared++;
    if (vcount - v0 != SYM) begin mismatched++; $display("FAIL flush_count: got %0d outputs, required %0d", vcount - v0, SYM); end
  endtask

  task automatic test_rst_mid();
    int v0 = vcount;
    int budget = 300;
    for (int k = 0; k < N; k++) send(16'(200 + k), 16'(k), 0);
    idle(1);
    while (vcount - v0 < 40 && budget > 0) begin @(negedge clk); budget--; end
    #2;
    rst = 1'b1;
    exp_q.delete();
    wcnt = 0;
    #1;
    compared++;
    if ({out_valid, in_ready} !== 2'b01) begin mismatched++; $display("FAIL rst_mid: valid=%0b ready=%0b, required 0 1", out_valid, in_ready); end
    @(negedge clk); #2; rst = 1'b0;
    v0 = vcount;
    for (int k = 0; k < N; k++) send(16'(300 + k), 16'(-k), 0);
    drain();
    compared++;
    if (vcount - v0 != SYM) begin mismatched++; $display("FAIL rst_fresh_count: got %0d outputs, required %0d", vcount - v0, SYM); end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_sparse();
    test_flush();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
